// File: rtl/burst_sequencer_if.sv
// Purpose : signal bundle between burst_sequencer and its surroundings
//           (host control, data generator and downstream FIFO status).
// Ports   : master modport - host/generator side driving requests and strobes
//           slave modport  - burst_sequencer side
//   start_in, stop_in, burst_count_in[15:0]  host control requests
//   fifo_free_in[15:0]                       downstream FIFO free word count
//   gen_valid_in                             generator valid strobe
//   gen_trigger_out                          trigger to generator
//   busy_out, done_out, bursts_done_out[15:0],
//   timeout_err_out, stray_valid_err_out     status back to host
interface burst_sequencer_if;
    logic        start_in;
    logic        stop_in;
    logic [15:0] burst_count_in;
    logic [15:0] fifo_free_in;
    logic        gen_valid_in;
    logic        gen_trigger_out;
    logic        busy_out;
    logic        done_out;
    logic [15:0] bursts_done_out;
    logic        timeout_err_out;
    logic        stray_valid_err_out;

    modport master (
        output start_in, stop_in, burst_count_in, fifo_free_in, gen_valid_in,
        input  gen_trigger_out, busy_out, done_out, bursts_done_out,
               timeout_err_out, stray_valid_err_out
    );

    modport slave (
        input  start_in, stop_in, burst_count_in, fifo_free_in, gen_valid_in,
        output gen_trigger_out, busy_out, done_out, bursts_done_out,
               timeout_err_out, stray_valid_err_out
    );
endinterface

// File: rtl/burst_sequencer.sv
// Purpose : sequences the test-data generator into the FIFO path. Each burst
//           waits for FIFO room, pulses the generator trigger, counts the
//           returned valid words and spaces bursts apart. Reports progress,
//           completion and protocol errors to the host.
// Ports   : clk_in  - sole clock, rising edge
//           rst_in  - synchronous active-high reset
//           bus     - burst_sequencer_if.slave (host, generator, FIFO status)
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for start_in; status outputs hold last run's values
// S_WAIT_SPC | waiting for fifo_free_in >= BURST_LEN, or leaving on stop
// S_TRIG     | gen_trigger_out high for TRIG_CYCLES
// S_RUN      | counting generator valids until BURST_LEN or timeout
// S_GAP      | enforced low time on the trigger between bursts
module burst_sequencer #(
    parameter int unsigned BURST_LEN   = 8192,
    parameter int unsigned TRIG_CYCLES = 2,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    burst_sequencer_if.slave bus
);
    localparam logic [16:0] BURST_LEN_W = 17'(BURST_LEN);
    localparam logic [15:0] TRIG_LOAD   = 16'(TRIG_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD    = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] IDLE_LOAD   = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SPC,
        S_TRIG,
        S_RUN,
        S_GAP
    } state_t;

    state_t      state, state_next;
    logic [15:0] word_cnt;
    logic [15:0] trig_cnt;
    logic [15:0] gap_cnt;
    logic [15:0] idle_cnt;
    logic [15:0] target;
    logic        stop_pending;
    logic        start_acc;
    logic        burst_end;
    logic        timeout_hit;

    logic        trig_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] bursts_done_q;
    logic        timeout_err_q;
    logic        stray_err_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_acc   = 1'b0;
        burst_end   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start_in) begin
                    start_acc  = 1'b1;
                    state_next = S_WAIT_SPC;
                end
            end
            S_WAIT_SPC: begin
                if (stop_pending)                               state_next = S_IDLE;
                else if ({1'b0, bus.fifo_free_in} >= BURST_LEN_W) state_next = S_TRIG;
            end
            S_TRIG: begin
                if (trig_cnt == 16'd0) state_next = S_RUN;
            end
            S_RUN: begin
                if (bus.gen_valid_in) begin
                    if ({1'b0, word_cnt} + 17'd1 == BURST_LEN_W) begin
                        burst_end = 1'b1;
                        // target compare uses the pre-increment count
                        if (stop_pending ||
                            (target != 16'd0 && {1'b0, bursts_done_q} + 17'd1 == {1'b0, target}))
                            state_next = S_IDLE;
                        else
                            state_next = S_GAP;
                    end
                end else if (idle_cnt == 16'd0) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_GAP: begin
                if (stop_pending)          state_next = S_IDLE;
                else if (gap_cnt == 16'd0) state_next = S_WAIT_SPC;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            word_cnt      <= '0;
            trig_cnt      <= '0;
            gap_cnt       <= '0;
            idle_cnt      <= '0;
            target        <= '0;
            stop_pending  <= 1'b0;
            trig_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            bursts_done_q <= '0;
            timeout_err_q <= 1'b0;
            stray_err_q   <= 1'b0;
        end else begin
            // outputs come from next-state decode so they line up with the state
            trig_q <= (state_next == S_TRIG);
            busy_q <= (state_next != S_IDLE);
            done_q <= (state != S_IDLE) && (state_next == S_IDLE);

            if (state_next == S_IDLE)
                stop_pending <= 1'b0;
            else if (bus.stop_in && state != S_IDLE)
                stop_pending <= 1'b1;

            if (state_next == S_TRIG && state != S_TRIG)
                trig_cnt <= TRIG_LOAD;
            else if (state == S_TRIG && trig_cnt != 16'd0)
                trig_cnt <= trig_cnt - 16'd1;

            if (state_next == S_GAP && state != S_GAP)
                gap_cnt <= GAP_LOAD;
            else if (state == S_GAP && gap_cnt != 16'd0)
                gap_cnt <= gap_cnt - 16'd1;

            // idle timer is a down-counter reloaded on every valid word
            if (state == S_TRIG) begin
                word_cnt <= '0;
                idle_cnt <= IDLE_LOAD;
            end else if (state == S_RUN) begin
                if (bus.gen_valid_in) begin
                    word_cnt <= word_cnt + 16'd1;
                    idle_cnt <= IDLE_LOAD;
                end else if (idle_cnt != 16'd0) begin
                    idle_cnt <= idle_cnt - 16'd1;
                end
            end

            if (start_acc) begin
                target        <= bus.burst_count_in;
                bursts_done_q <= '0;
                timeout_err_q <= 1'b0;
                stray_err_q   <= 1'b0;
            end else begin
                if (burst_end && bursts_done_q != 16'hFFFF)
                    bursts_done_q <= bursts_done_q + 16'd1;
                if (timeout_hit)
                    timeout_err_q <= 1'b1;
            end

            // a stray valid coinciding with start is still reported
            if (bus.gen_valid_in && state != S_RUN)
                stray_err_q <= 1'b1;
        end
    end

    assign bus.gen_trigger_out     = trig_q;
    assign bus.busy_out            = busy_q;
    assign bus.done_out            = done_q;
    assign bus.bursts_done_out     = bursts_done_q;
    assign bus.timeout_err_out     = timeout_err_q;
    assign bus.stray_valid_err_out = stray_err_q;
endmodule

// File: tb/tb_burst_sequencer.sv
// Testbench for burst_sequencer: directed sequence with randomised generator
// bubbles and FIFO levels, checked against a burst-level expectation model.
module tb_burst_sequencer;
    localparam int BURST_LEN   = 8192;
    localparam int TRIG_CYCLES = 2;
    localparam int GAP_CYCLES  = 4;
    localparam int TIMEOUT     = 16;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    burst_sequencer_if bus_if ();

    burst_sequencer #(
        .BURST_LEN  (BURST_LEN),
        .TRIG_CYCLES(TRIG_CYCLES),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus_if)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;
    int exp_bursts  = 0;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference rule: a run finishes after a completed burst when a stop was
    // requested or the requested number of bursts has been reached.
    function automatic bit run_ends(input int done_bursts, input int tgt, input bit stop_req);
        return stop_req || (tgt != 0 && done_bursts == tgt);
    endfunction

    task automatic wait_trigger(input string tag, input int bound, output int low_cycles);
        low_cycles = 0;
        while (bus_if.gen_trigger_out !== 1'b1 && low_cycles < bound) begin
            step();
            low_cycles++;
        end
        check_bit({tag, "_trig_seen"}, bus_if.gen_trigger_out, 1'b1);
    endtask

    task automatic trigger_pulse(input string tag);
        int width = 0;
        while (bus_if.gen_trigger_out === 1'b1 && width < 100) begin
            step();
            width++;
        end
        check_val({tag, "_trig_width"}, 32'(width), 32'(TRIG_CYCLES));
    endtask

    // Generator model: n_words valid strobes with random short bubbles;
    // stop_in is pulsed alongside word number stop_at (if >= 0).
    task automatic drive_words(input string tag, input int n_words, input int stop_at);
        int sent = 0;
        while (sent < n_words) begin
            if ($urandom_range(0, 15) == 0) begin
                bus_if.gen_valid_in = 1'b0;
                repeat ($urandom_range(1, 3)) step();
            end
            bus_if.gen_valid_in = 1'b1;
            bus_if.stop_in      = (sent == stop_at);
            step();
            sent++;
            bus_if.stop_in = 1'b0;
            if (sent == BURST_LEN) exp_bursts++;
            check_val({tag, "_bursts_done"}, 32'(bus_if.bursts_done_out), 32'(exp_bursts));
        end
        bus_if.gen_valid_in = 1'b0;
    endtask

    // Called right after the edge that accepted a start with FIFO room.
    task automatic run_sequence(input string tag, input int tgt, input int stop_burst,
                                input int stray_burst);
        int low;
        bit ended    = 1'b0;
        bit stop_req = 1'b0;
        check_bit({tag, "_busy_n1"}, bus_if.busy_out, 1'b1);
        check_bit({tag, "_trig_n1"}, bus_if.gen_trigger_out, 1'b0);
        step();
        check_bit({tag, "_trig_n2"}, bus_if.gen_trigger_out, 1'b1);
        for (int b = 1; b <= 8 && !ended; b++) begin
            trigger_pulse(tag);
            drive_words(tag, BURST_LEN, (b == stop_burst) ? BURST_LEN / 2 : -1);
            if (b == stop_burst) stop_req = 1'b1;
            ended = run_ends(exp_bursts, tgt, stop_req);
            check_bit({tag, "_done_at_end"}, bus_if.done_out, ended);
            check_bit({tag, "_busy_at_end"}, bus_if.busy_out, !ended);
            if (b == stray_burst) begin
                bus_if.gen_valid_in = 1'b1;
                step();
                bus_if.gen_valid_in = 1'b0;
                check_bit({tag, "_stray_set"}, bus_if.stray_valid_err_out, 1'b1);
            end
            if (!ended) begin
                wait_trigger(tag, 64, low);
                check_val({tag, "_gap_low"}, 32'(low),
                          32'(GAP_CYCLES + 1 - ((b == stray_burst) ? 1 : 0)));
            end
        end
    endtask

    task automatic quiet_window(input string tag);
        int trigs = 0;
        int dones = 0;
        repeat (20) begin
            step();
            if (bus_if.gen_trigger_out === 1'b1) trigs++;
            if (bus_if.done_out === 1'b1) dones++;
        end
        check_val({tag, "_late_trigs"}, 32'(trigs), 32'd0);
        check_val({tag, "_late_dones"}, 32'(dones), 32'd0);
    endtask

    task automatic start_run(input logic [15:0] count, input logic [15:0] free);
        bus_if.burst_count_in = count;
        bus_if.fifo_free_in   = free;
        bus_if.start_in       = 1'b1;
        step();
        bus_if.start_in = 1'b0;
        exp_bursts      = 0;
    endtask

    initial begin
        int low;
        int trigs;
        bus_if.start_in       = 1'b0;
        bus_if.stop_in        = 1'b0;
        bus_if.burst_count_in = '0;
        bus_if.fifo_free_in   = '0;
        bus_if.gen_valid_in   = 1'b0;

        rst_in = 1'b1;
        repeat (3) step();
        check_bit("rst_busy",   bus_if.busy_out, 1'b0);
        check_bit("rst_done",   bus_if.done_out, 1'b0);
        check_bit("rst_trig",   bus_if.gen_trigger_out, 1'b0);
        check_val("rst_bursts", 32'(bus_if.bursts_done_out), 32'd0);
        check_bit("rst_tmo",    bus_if.timeout_err_out, 1'b0);
        check_bit("rst_stray",  bus_if.stray_valid_err_out, 1'b0);
        rst_in = 1'b0;
        step();

        // Two counted bursts, plenty of FIFO room.
        start_run(16'd2, 16'd9000);
        run_sequence("t1", 2, -1, -1);
        check_val("t1_bursts_final", 32'(bus_if.bursts_done_out), 32'd2);
        quiet_window("t1");
        check_bit("t1_busy_idle", bus_if.busy_out, 1'b0);
        check_bit("t1_tmo",       bus_if.timeout_err_out, 1'b0);
        check_bit("t1_stray",     bus_if.stray_valid_err_out, 1'b0);

        // Continuous mode, stray valid after burst 1, stop during burst 3.
        start_run(16'd0, 16'($urandom_range(BURST_LEN, 65535)));
        check_bit("t3_stray_clear", bus_if.stray_valid_err_out, 1'b0);
        run_sequence("t3", 0, 3, 1);
        check_val("t3_bursts_final", 32'(bus_if.bursts_done_out), 32'd3);
        quiet_window("t3");
        check_bit("t3_stray_held", bus_if.stray_valid_err_out, 1'b1);
        check_bit("t3_tmo",        bus_if.timeout_err_out, 1'b0);

        // Generator silent after trigger: timeout.
        start_run(16'd1, 16'd9000);
        check_bit("t4_stray_cleared", bus_if.stray_valid_err_out, 1'b0);
        wait_trigger("t4", 8, low);
        trigger_pulse("t4");
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            check_bit("t4_no_early_done", bus_if.done_out, 1'b0);
        end
        step();
        check_bit("t4_done",   bus_if.done_out, 1'b1);
        check_bit("t4_tmo",    bus_if.timeout_err_out, 1'b1);
        check_bit("t4_busy",   bus_if.busy_out, 1'b0);
        check_val("t4_bursts", 32'(bus_if.bursts_done_out), 32'd0);
        step();
        check_bit("t4_done_1cyc", bus_if.done_out, 1'b0);
        check_bit("t4_tmo_held",  bus_if.timeout_err_out, 1'b1);

        // FIFO threshold, then reset mid-burst, then a fresh full burst.
        start_run(16'd1, 16'd8191);
        check_bit("t2_tmo_cleared", bus_if.timeout_err_out, 1'b0);
        trigs = 0;
        repeat (50) begin
            step();
            if (bus_if.gen_trigger_out === 1'b1) trigs++;
        end
        check_val("t2_no_trig_8191", 32'(trigs), 32'd0);
        check_bit("t2_busy_waiting", bus_if.busy_out, 1'b1);
        bus_if.fifo_free_in = 16'd8192;
        step();
        check_bit("t2_trig_at_8192", bus_if.gen_trigger_out, 1'b1);
        trigger_pulse("t2");
        drive_words("t6", 4000, -1);
        rst_in = 1'b1;
        step();
        check_bit("t6_busy",   bus_if.busy_out, 1'b0);
        check_bit("t6_done",   bus_if.done_out, 1'b0);
        check_bit("t6_trig",   bus_if.gen_trigger_out, 1'b0);
        check_val("t6_bursts", 32'(bus_if.bursts_done_out), 32'd0);
        check_bit("t6_tmo",    bus_if.timeout_err_out, 1'b0);
        check_bit("t6_stray",  bus_if.stray_valid_err_out, 1'b0);
        rst_in = 1'b0;
        step();
        start_run(16'd1, 16'd9000);
        run_sequence("t6r", 1, -1, -1);
        check_val("t6r_bursts_final", 32'(bus_if.bursts_done_out), 32'd1);
        check_bit("t6r_tmo",   bus_if.timeout_err_out, 1'b0);
        check_bit("t6r_stray", bus_if.stray_valid_err_out, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
